// File: rtl/core_lsu_bridge.sv
// Load/store bridge: registers one core data access, issues a word-aligned bus
// access with byte enables and replicated store data, returns right-justified loads.
module core_lsu_bridge #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wr_data,
    input  logic [1:0]      i_size,
    input  logic            i_wr_en,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_ack,
    output logic            o_err,
    output logic            o_misaligned,
    output logic [XLEN-1:0] o_bus_addr,
    output logic [XLEN-1:0] o_bus_wdata,
    output logic [3:0]      o_bus_be,
    output logic            o_bus_we,
    output logic            o_bus_req,
    input  logic            i_bus_gnt,
    input  logic            i_bus_rvalid,
    input  logic [XLEN-1:0] i_bus_rdata,
    input  logic            i_bus_err
);
    // state | meaning
    // IDLE  | waiting for a core request (ignored while o_ack is high)
    // ADDR  | bus request held until grant
    // RESP  | read granted, waiting for rvalid
    // ERR   | misaligned/reserved-size ack cycle, no bus activity
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_RESP, ST_ERR} state_t;

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       size_q, size_d;
    logic [1:0]       off_q, off_d;

    logic [XLEN-1:0]  rd_data_d, bus_addr_d, bus_wdata_d;
    logic [3:0]       bus_be_d;
    logic             bus_we_d, bus_req_d, ack_d, err_d, mis_d;

    logic             req_misaligned;
    logic [3:0]       req_be;
    logic [XLEN-1:0]  req_wdata;
    logic [XLEN-1:0]  rd_shift, rd_fmt;
    logic             timeout;

    always_comb begin
        req_misaligned = 1'b0;
        req_be         = 4'b1111;
        req_wdata      = i_wr_data;
        case (i_size)
            2'd0: begin
                req_be    = 4'b0001 << i_addr[1:0];
                req_wdata = {4{i_wr_data[7:0]}};
            end
            2'd1: begin
                req_misaligned = i_addr[0];
                req_be         = i_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata      = {2{i_wr_data[15:0]}};
            end
            2'd2: req_misaligned = (i_addr[1:0] != 2'b00);
            default: req_misaligned = 1'b1;
        endcase
    end

    // Loads are shifted down by the latched byte offset, then zero-filled to size.
    always_comb begin
        rd_shift = i_bus_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    rd_fmt = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
            2'd1:    rd_fmt = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
            default: rd_fmt = rd_shift;
        endcase
    end

    assign timeout = (cnt_q >= CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        size_d      = size_q;
        off_d       = off_q;
        rd_data_d   = o_rd_data;
        bus_addr_d  = o_bus_addr;
        bus_wdata_d = o_bus_wdata;
        bus_be_d    = o_bus_be;
        bus_we_d    = o_bus_we;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        mis_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req && !o_ack) begin
                    if (req_misaligned) begin
                        state_d   = ST_ERR;
                        ack_d     = 1'b1;
                        err_d     = 1'b1;
                        mis_d     = 1'b1;
                        rd_data_d = '0;
                    end else begin
                        state_d     = ST_ADDR;
                        size_d      = i_size;
                        off_d       = i_addr[1:0];
                        bus_addr_d  = {i_addr[XLEN-1:2], 2'b00};
                        bus_wdata_d = req_wdata;
                        bus_be_d    = req_be;
                        bus_we_d    = i_wr_en;
                    end
                end
            end
            // A handshake in the final cycle wins over the timeout.
            ST_ADDR: begin
                if (i_bus_gnt) begin
                    if (o_bus_we) begin
                        state_d = ST_IDLE;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else if (timeout) begin
                    state_d   = ST_IDLE;
                    ack_d     = 1'b1;
                    err_d     = 1'b1;
                    rd_data_d = '0;
                end
            end
            ST_RESP: begin
                if (i_bus_rvalid) begin
                    state_d   = ST_IDLE;
                    ack_d     = 1'b1;
                    err_d     = i_bus_err;
                    rd_data_d = i_bus_err ? '0 : rd_fmt;
                end else if (timeout) begin
                    state_d   = ST_IDLE;
                    ack_d     = 1'b1;
                    err_d     = 1'b1;
                    rd_data_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_IDLE || (state_d != ST_ADDR && state_d != ST_RESP)) begin
            cnt_d = '0;
        end
        bus_req_d = (state_d == ST_ADDR);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            size_q       <= '0;
            off_q        <= '0;
            o_rd_data    <= '0;
            o_ack        <= 1'b0;
            o_err        <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_addr   <= '0;
            o_bus_wdata  <= '0;
            o_bus_be     <= '0;
            o_bus_we     <= 1'b0;
            o_bus_req    <= 1'b0;
        end else begin
            size_q       <= size_d;
            off_q        <= off_d;
            o_rd_data    <= rd_data_d;
            o_ack        <= ack_d;
            o_err        <= err_d;
            o_misaligned <= mis_d;
            o_bus_addr   <= bus_addr_d;
            o_bus_wdata  <= bus_wdata_d;
            o_bus_be     <= bus_be_d;
            o_bus_we     <= bus_we_d;
            o_bus_req    <= bus_req_d;
        end
    end

endmodule

// File: tb/tb_core_lsu_bridge.sv
// Directed bench for core_lsu_bridge with a short timeout (8 cycles).
module tb_core_lsu_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wr_data = '0;
    logic [1:0]  size = '0;
    logic        wr_en = 1'b0;
    logic [31:0] rd_data;
    logic        ack, err, misaligned;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_we, bus_req;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    core_lsu_bridge #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_addr(addr), .i_wr_data(wr_data),
        .i_size(size), .i_wr_en(wr_en), .o_rd_data(rd_data), .o_ack(ack), .o_err(err),
        .o_misaligned(misaligned), .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata),
        .o_bus_be(bus_be), .o_bus_we(bus_we), .o_bus_req(bus_req), .i_bus_gnt(bus_gnt),
        .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata), .i_bus_err(bus_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] s, input logic w,
                         input logic [31:0] d);
        req = 1'b1; addr = a; size = s; wr_en = w; wr_data = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if ({ack, err, misaligned, bus_req, bus_we} !== 5'b0) begin
            bad++; $display("FAIL reset_ctl: got %b want 00000", {ack, err, misaligned, bus_req, bus_we});
        end
        total++;
        if (rd_data !== 32'h0) begin
            bad++; $display("FAIL reset_rd_data: got %h want 00000000", rd_data);
        end
        total++;
        if ({bus_addr, bus_wdata, bus_be} !== 68'h0) begin
            bad++; $display("FAIL reset_bus: got addr=%h wdata=%h be=%b want all 0", bus_addr, bus_wdata, bus_be);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (bus_req !== 1'b0) begin
            bad++; $display("FAIL idle_no_req: got %b want 0", bus_req);
        end
    endtask

    task automatic test_word_store();
        int req_cycles = 0;
        drive(32'h100, 2'd2, 1'b1, 32'hDEADBEEF);
        tick();
        total++;
        if (bus_addr !== 32'h100 || bus_be !== 4'b1111 || bus_we !== 1'b1 || bus_wdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL word_store_fields: got addr=%h be=%b we=%b wdata=%h want 00000100 1111 1 deadbeef",
                            bus_addr, bus_be, bus_we, bus_wdata);
        end
        for (int c = 1; c <= 4; c++) begin
            if (bus_req === 1'b1) req_cycles++;
            total++;
            if (ack !== 1'b0) begin
                bad++; $display("FAIL word_store_early_ack c%0d: got %b want 0", c, ack);
            end
            if (c == 4) bus_gnt = 1'b1;
            tick();
        end
        bus_gnt = 1'b0;
        total++;
        if (req_cycles != 4) begin
            bad++; $display("FAIL word_store_req_len: got %0d want 4", req_cycles);
        end
        total++;
        if (ack !== 1'b1 || err !== 1'b0 || bus_req !== 1'b0) begin
            bad++; $display("FAIL word_store_ack: got ack=%b err=%b req=%b want 1 0 0", ack, err, bus_req);
        end
        tick();
        total++;
        if (ack !== 1'b0 || bus_req !== 1'b0) begin
            bad++; $display("FAIL word_store_no_reaccept: got ack=%b req=%b want 0 0", ack, bus_req);
        end
        req = 1'b0;
        tick();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [1:0]  s;
        logic [31:0] rdata;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] exp;
    } load_vec_t;

    task automatic test_loads();
        load_vec_t v[5];
        v[0] = '{32'h203, 2'd0, 32'hA1B2C3D4, 32'h200, 4'b1000, 32'h000000A1};
        v[1] = '{32'h301, 2'd0, 32'h11223344, 32'h300, 4'b0010, 32'h00000033};
        v[2] = '{32'h102, 2'd1, 32'h5678ABCD, 32'h100, 4'b1100, 32'h00005678};
        v[3] = '{32'h400, 2'd2, 32'hCAFEF00D, 32'h400, 4'b1111, 32'hCAFEF00D};
        v[4] = '{32'h100, 2'd1, 32'hFFFF8001, 32'h100, 4'b0011, 32'h00008001};
        for (int i = 0; i < 5; i++) begin
            drive(v[i].a, v[i].s, 1'b0, 32'h0);
            tick();
            total++;
            if (bus_req !== 1'b1 || bus_addr !== v[i].baddr || bus_be !== v[i].be || bus_we !== 1'b0) begin
                bad++; $display("FAIL load%0d_bus: got req=%b addr=%h be=%b we=%b want 1 %h %b 0",
                                i, bus_req, bus_addr, bus_be, bus_we, v[i].baddr, v[i].be);
            end
            bus_gnt = 1'b1;
            tick();
            bus_gnt = 1'b0;
            total++;
            if (bus_req !== 1'b0 || ack !== 1'b0) begin
                bad++; $display("FAIL load%0d_resp_wait: got req=%b ack=%b want 0 0", i, bus_req, ack);
            end
            bus_rvalid = 1'b1; bus_rdata = v[i].rdata;
            tick();
            bus_rvalid = 1'b0;
            total++;
            if (ack !== 1'b1 || err !== 1'b0 || rd_data !== v[i].exp) begin
                bad++; $display("FAIL load%0d_data: got ack=%b err=%b rd=%h want 1 0 %h",
                                i, ack, err, rd_data, v[i].exp);
            end
            req = 1'b0;
            tick();
        end
    endtask

    task automatic test_half_store();
        drive(32'h102, 2'd1, 1'b1, 32'h00001234);
        tick();
        total++;
        if (bus_be !== 4'b1100 || bus_wdata !== 32'h12341234 || bus_we !== 1'b1 || bus_addr !== 32'h100) begin
            bad++; $display("FAIL half_store_fields: got be=%b wdata=%h we=%b addr=%h want 1100 12341234 1 00000100",
                            bus_be, bus_wdata, bus_we, bus_addr);
        end
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        total++;
        if (ack !== 1'b1 || err !== 1'b0 || rd_data !== 32'h00008001) begin
            bad++; $display("FAIL half_store_ack: got ack=%b err=%b rd=%h want 1 0 00008001", ack, err, rd_data);
        end
        req = 1'b0;
        tick();
    endtask

    task automatic test_misaligned();
        logic [31:0] a[3];
        logic [1:0]  s[3];
        a[0] = 32'h101; s[0] = 2'd2;
        a[1] = 32'h100; s[1] = 2'd3;
        a[2] = 32'h103; s[2] = 2'd1;
        for (int i = 0; i < 3; i++) begin
            drive(a[i], s[i], 1'b0, 32'h0);
            tick();
            total++;
            if (ack !== 1'b1 || err !== 1'b1 || misaligned !== 1'b1 || rd_data !== 32'h0 || bus_req !== 1'b0) begin
                bad++; $display("FAIL misalign%0d_ack: got ack=%b err=%b mis=%b rd=%h req=%b want 1 1 1 0 0",
                                i, ack, err, misaligned, rd_data, bus_req);
            end
            tick();
            total++;
            if (ack !== 1'b0 || bus_req !== 1'b0) begin
                bad++; $display("FAIL misalign%0d_after: got ack=%b req=%b want 0 0", i, ack, bus_req);
            end
            req = 1'b0;
            tick();
        end
    endtask

    task automatic test_bus_err();
        drive(32'h600, 2'd2, 1'b0, 32'h0);
        tick();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'h0BADF00D;
        tick();
        bus_rvalid = 1'b0;
        req = 1'b0;
        total++;
        if (ack !== 1'b1 || err !== 1'b0 || rd_data !== 32'h0BADF00D) begin
            bad++; $display("FAIL bus_ok_load: got ack=%b err=%b rd=%h want 1 0 0badf00d", ack, err, rd_data);
        end
        tick();
        drive(32'h604, 2'd2, 1'b0, 32'h0);
        tick();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1; bus_err = 1'b1; bus_rdata = 32'hFFFFFFFF;
        tick();
        bus_rvalid = 1'b0; bus_err = 1'b0;
        total++;
        if (ack !== 1'b1 || err !== 1'b1 || misaligned !== 1'b0 || rd_data !== 32'h0) begin
            bad++; $display("FAIL bus_err_ack: got ack=%b err=%b mis=%b rd=%h want 1 1 0 0", ack, err, misaligned, rd_data);
        end
        req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        drive(32'h500, 2'd2, 1'b0, 32'h0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (bus_req === 1'b1) req_cycles++;
            total++;
            if (ack !== 1'b0) begin
                bad++; $display("FAIL timeout_early_ack c%0d: got %b want 0", c, ack);
            end
        end
        total++;
        if (req_cycles != 8) begin
            bad++; $display("FAIL timeout_req_len: got %0d want 8", req_cycles);
        end
        tick();
        total++;
        if (ack !== 1'b1 || err !== 1'b1 || misaligned !== 1'b0 || bus_req !== 1'b0) begin
            bad++; $display("FAIL timeout_ack: got ack=%b err=%b mis=%b req=%b want 1 1 0 0", ack, err, misaligned, bus_req);
        end
        req = 1'b0;
        tick();
        bus_rvalid = 1'b1; bus_rdata = 32'h55555555;
        tick();
        bus_rvalid = 1'b0;
        tick();
        total++;
        if (ack !== 1'b0 || rd_data !== 32'h0) begin
            bad++; $display("FAIL timeout_stray_rvalid: got ack=%b rd=%h want 0 0", ack, rd_data);
        end
    endtask

    task automatic test_resp_timeout();
        drive(32'h504, 2'd2, 1'b0, 32'h0);
        tick();
        bus_gnt = 1'b1;
        for (int c = 2; c <= 8; c++) begin
            tick();
            bus_gnt = 1'b0;
            total++;
            if (ack !== 1'b0 || bus_req !== 1'b0) begin
                bad++; $display("FAIL resp_timeout_wait c%0d: got ack=%b req=%b want 0 0", c, ack, bus_req);
            end
        end
        tick();
        total++;
        if (ack !== 1'b1 || err !== 1'b1 || misaligned !== 1'b0) begin
            bad++; $display("FAIL resp_timeout_ack: got ack=%b err=%b mis=%b want 1 1 0", ack, err, misaligned);
        end
        req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        drive(32'h700, 2'd2, 1'b0, 32'h0);
        tick();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        tick();
        bus_rvalid = 1'b0;
        req = 1'b0;
        total++;
        if (ack !== 1'b1 || rd_data !== 32'h12345678) begin
            bad++; $display("FAIL pre_reset_load: got ack=%b rd=%h want 1 12345678", ack, rd_data);
        end
        tick();
        drive(32'h704, 2'd2, 1'b0, 32'h0);
        tick();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({ack, err, misaligned, bus_req, bus_we} !== 5'b0 || rd_data !== 32'h0 ||
            bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_be !== 4'h0) begin
            bad++; $display("FAIL reset_mid_outputs: got ctl=%b rd=%h addr=%h wdata=%h be=%b want all 0",
                            {ack, err, misaligned, bus_req, bus_we}, rd_data, bus_addr, bus_wdata, bus_be);
        end
        req = 1'b0;
        tick();
        rst_n = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'hABCD0123;
        tick();
        bus_rvalid = 1'b0;
        tick();
        total++;
        if (ack !== 1'b0 || rd_data !== 32'h0) begin
            bad++; $display("FAIL reset_mid_no_ack: got ack=%b rd=%h want 0 0", ack, rd_data);
        end
        drive(32'h803, 2'd0, 1'b1, 32'h000000AB);
        tick();
        total++;
        if (bus_req !== 1'b1 || bus_be !== 4'b1000 || bus_wdata !== 32'hABABABAB || bus_addr !== 32'h800) begin
            bad++; $display("FAIL post_reset_store: got req=%b be=%b wdata=%h addr=%h want 1 1000 abababab 00000800",
                            bus_req, bus_be, bus_wdata, bus_addr);
        end
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        total++;
        if (ack !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL post_reset_ack: got ack=%b err=%b want 1 0", ack, err);
        end
        req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        bus_gnt = 1'b1;
        drive(32'h900, 2'd2, 1'b1, 32'h00000001);
        tick();
        tick();
        total++;
        if (ack !== 1'b1 || bus_req !== 1'b0) begin
            bad++; $display("FAIL b2b_first_ack: got ack=%b req=%b want 1 0", ack, bus_req);
        end
        tick();
        total++;
        if (bus_req !== 1'b0 || ack !== 1'b0) begin
            bad++; $display("FAIL b2b_gap: got req=%b ack=%b want 0 0", bus_req, ack);
        end
        drive(32'h904, 2'd2, 1'b1, 32'h00000002);
        tick();
        total++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h904 || bus_wdata !== 32'h2 || ack !== 1'b0) begin
            bad++; $display("FAIL b2b_second_req: got req=%b addr=%h wdata=%h ack=%b want 1 00000904 00000002 0",
                            bus_req, bus_addr, bus_wdata, ack);
        end
        tick();
        bus_gnt = 1'b0;
        total++;
        if (ack !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL b2b_second_ack: got ack=%b err=%b want 1 0", ack, err);
        end
        req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_loads();
        test_half_store();
        test_misaligned();
        test_bus_err();
        test_timeout();
        test_resp_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
